// File: rtl/ex_stage_muldiv.sv
// Execute stage: single-cycle ALU plus an iterative 32-step unsigned mul/div engine.
// Drives the EX/MEM pipeline register and stalls upstream while the engine runs.
module ex_stage_muldiv #(
    parameter logic [31:0] NOP_INSTR = 32'h00000020,
    parameter int unsigned ITER      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_a,
    input  logic [31:0] ex_b,
    input  logic [31:0] ex_d2,
    input  logic [4:0]  ex_td,
    input  logic [4:0]  ex_Aluc,
    input  logic        ex_WREG,
    input  logic        ex_WMEM,
    input  logic        ex_LW,
    input  logic [31:0] ex_instr,
    input  logic [31:0] ex_pc,
    output logic        ex_busy,
    output logic [31:0] mem_alu,
    output logic [31:0] mem_d2,
    output logic [4:0]  mem_td,
    output logic        mem_WREG,
    output logic        mem_WMEM,
    output logic        mem_LW,
    output logic [31:0] mem_instr,
    output logic [31:0] mem_pc
);

    localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [31:0]   a_q, b_q, hi_q, lo_q, hi_d, lo_d;
    logic [1:0]    op_q;
    logic          is_iter, busy;
    logic [31:0]   alu_res, eng_res;
    logic [4:0]    shamt;
    logic [32:0]   mul_sum, div_shift;
    logic [33:0]   div_diff;

    logic [31:0] mem_alu_d, mem_d2_d, mem_instr_d, mem_pc_d;
    logic [4:0]  mem_td_d;
    logic        mem_WREG_d, mem_WMEM_d, mem_LW_d;

    // Codes 16..19 are the iterative ops; 20..31 fall through as single-cycle zero.
    assign is_iter = (ex_Aluc[4:2] == 3'b100);
    assign shamt   = ex_a[4:0];

    always_comb begin
        alu_res = '0;
        case (ex_Aluc)
            5'd0:    alu_res = ex_a + ex_b;
            5'd1:    alu_res = ex_a - ex_b;
            5'd2:    alu_res = ex_a & ex_b;
            5'd3:    alu_res = ex_a | ex_b;
            5'd4:    alu_res = ex_a ^ ex_b;
            5'd5:    alu_res = ~(ex_a | ex_b);
            5'd6:    alu_res = {31'b0, $signed(ex_a) < $signed(ex_b)};
            5'd7:    alu_res = {31'b0, ex_a < ex_b};
            5'd8:    alu_res = ex_b << shamt;
            5'd9:    alu_res = ex_b >> shamt;
            5'd10:   alu_res = $signed(ex_b) >>> shamt;
            5'd11:   alu_res = {ex_b[15:0], 16'h0};
            default: alu_res = '0;
        endcase
    end

    // {hi,lo} is the product shift register for mul, {remainder,quotient} for div.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : 33'd0);
        div_shift = {hi_q, lo_q[31]};
        div_diff  = {1'b0, div_shift} - {2'b0, b_q};
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (op_q[1]) begin
            if (!div_diff[33]) begin
                hi_d = div_diff[31:0];
                lo_d = {lo_q[30:0], 1'b1};
            end else begin
                hi_d = div_shift[31:0];
                lo_d = {lo_q[30:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[32:1];
            lo_d = {mul_sum[0], lo_q[31:1]};
        end
    end

    // MUL/DIVU take the low/quotient half, MULHU/REMU the high/remainder half.
    assign eng_res = op_q[0] ? hi_q : lo_q;

    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        mem_alu_d   = '0;
        mem_d2_d    = '0;
        mem_td_d    = '0;
        mem_WREG_d  = 1'b0;
        mem_WMEM_d  = 1'b0;
        mem_LW_d    = 1'b0;
        mem_instr_d = NOP_INSTR;
        mem_pc_d    = ex_pc;
        unique case (state_q)
            StIdle: begin
                if (is_iter) begin
                    busy    = 1'b1;
                    state_d = StBusy;
                end else begin
                    mem_alu_d   = alu_res;
                    mem_d2_d    = ex_d2;
                    mem_td_d    = ex_td;
                    mem_WREG_d  = ex_WREG;
                    mem_WMEM_d  = ex_WMEM;
                    mem_LW_d    = ex_LW;
                    mem_instr_d = ex_instr;
                end
            end
            StBusy: begin
                busy = 1'b1;
                if (cnt_q == CW'(ITER - 1)) state_d = StDone;
            end
            StDone: begin
                mem_alu_d   = eng_res;
                mem_d2_d    = ex_d2;
                mem_td_d    = ex_td;
                mem_WREG_d  = ex_WREG;
                mem_WMEM_d  = ex_WMEM;
                mem_LW_d    = ex_LW;
                mem_instr_d = ex_instr;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // No operation can start while reset is held, so the stall is suppressed too.
    assign ex_busy = busy & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mem_alu   <= '0;
            mem_d2    <= '0;
            mem_td    <= '0;
            mem_WREG  <= 1'b0;
            mem_WMEM  <= 1'b0;
            mem_LW    <= 1'b0;
            mem_instr <= NOP_INSTR;
            mem_pc    <= '0;
        end else begin
            state_q   <= state_d;
            mem_alu   <= mem_alu_d;
            mem_d2    <= mem_d2_d;
            mem_td    <= mem_td_d;
            mem_WREG  <= mem_WREG_d;
            mem_WMEM  <= mem_WMEM_d;
            mem_LW    <= mem_LW_d;
            mem_instr <= mem_instr_d;
            mem_pc    <= mem_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (state_q == StIdle && is_iter) begin
            cnt_q <= '0;
            a_q   <= ex_a;
            b_q   <= ex_b;
            op_q  <= ex_Aluc[1:0];
            hi_q  <= '0;
            lo_q  <= ex_Aluc[1] ? ex_a : ex_b;
        end else if (state_q == StBusy) begin
            cnt_q <= cnt_q + CW'(1);
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Self-checking bench for ex_stage_muldiv: directed vector table, multi-cycle
// corner sequences, and randomized ops against an arithmetic reference model.
module tb_ex_stage_muldiv;

    localparam logic [31:0] NOP = 32'h00000020;

    logic        clk, rst;
    logic [31:0] ex_a, ex_b, ex_d2, ex_instr, ex_pc;
    logic [4:0]  ex_td, ex_Aluc;
    logic        ex_WREG, ex_WMEM, ex_LW;
    logic        ex_busy;
    logic [31:0] mem_alu, mem_d2, mem_instr, mem_pc;
    logic [4:0]  mem_td;
    logic        mem_WREG, mem_WMEM, mem_LW;

    int n_vec = 0;
    int n_err = 0;

    ex_stage_muldiv dut (
        .clk      (clk),
        .rst      (rst),
        .ex_a     (ex_a),
        .ex_b     (ex_b),
        .ex_d2    (ex_d2),
        .ex_td    (ex_td),
        .ex_Aluc  (ex_Aluc),
        .ex_WREG  (ex_WREG),
        .ex_WMEM  (ex_WMEM),
        .ex_LW    (ex_LW),
        .ex_instr (ex_instr),
        .ex_pc    (ex_pc),
        .ex_busy  (ex_busy),
        .mem_alu  (mem_alu),
        .mem_d2   (mem_d2),
        .mem_td   (mem_td),
        .mem_WREG (mem_WREG),
        .mem_WMEM (mem_WMEM),
        .mem_LW   (mem_LW),
        .mem_instr(mem_instr),
        .mem_pc   (mem_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input int unsigned op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint unsigned p;
        int unsigned     sh;
        p  = longint'(a) * longint'(b);
        sh = a % 32;
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return ~(a | b);
            6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            7:  return (a < b) ? 32'd1 : 32'd0;
            8:  return b << sh;
            9:  return b >> sh;
            10: return 32'($signed(b) >>> sh);
            11: return b * 32'd65536;
            16: return p[31:0];
            17: return p[63:32];
            18: return (b == 0) ? 32'hFFFFFFFF : a / b;
            19: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Presents one op and checks its full EX/MEM effect; caller sits just after a clock edge.
    task automatic run_op(input logic [4:0] aluc, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        logic [31:0] d2, instr, pc;
        logic [4:0]  td;
        logic        wreg, wmem, lw;
        int          busy_cnt, bub_ok, cyc;
        d2 = $urandom; instr = $urandom; pc = $urandom; td = 5'($urandom);
        wreg = 1'($urandom); wmem = 1'($urandom); lw = 1'($urandom);
        ex_Aluc = aluc; ex_a = a; ex_b = b; ex_d2 = d2; ex_td = td;
        ex_WREG = wreg; ex_WMEM = wmem; ex_LW = lw; ex_instr = instr; ex_pc = pc;
        #1;
        if (aluc >= 16 && aluc <= 19) begin
            busy_cnt = 0; bub_ok = 0; cyc = 0;
            while (ex_busy && cyc < 40) begin
                busy_cnt++;
                @(posedge clk); #1;
                cyc++;
                if (mem_WREG == 0 && mem_WMEM == 0 && mem_LW == 0 && mem_alu == 0 &&
                    mem_d2 == 0 && mem_td == 0 && mem_instr == NOP && mem_pc == pc)
                    bub_ok++;
                // Live operands must not leak into the running engine.
                ex_a = $urandom; ex_b = $urandom;
                #1;
            end
            check({name, " busy_cycles"}, 32'(busy_cnt), 32'd33);
            check({name, " bubbles"}, 32'(bub_ok), 32'd33);
        end else begin
            check({name, " busy"}, {31'b0, ex_busy}, 32'd0);
        end
        @(posedge clk); #1;
        check({name, " alu"}, mem_alu, exp);
        check({name, " ctrl"}, {26'b0, mem_td, mem_WREG, mem_WMEM, mem_LW},
              {26'b0, td, wreg, wmem, lw});
        check({name, " instr"}, mem_instr, instr);
        check({name, " pc_d2"}, mem_pc ^ mem_d2, pc ^ d2);
    endtask

    initial begin
        tbl[0]  = '{5'd0,  32'hFFFFFFFE, 32'h3, 32'h00000001};
        tbl[1]  = '{5'd1,  32'hFFFFFFFE, 32'h3, 32'hFFFFFFFB};
        tbl[2]  = '{5'd2,  32'hFFFFFFFE, 32'h3, 32'h00000002};
        tbl[3]  = '{5'd3,  32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF};
        tbl[4]  = '{5'd4,  32'hFFFFFFFE, 32'h3, 32'hFFFFFFFD};
        tbl[5]  = '{5'd5,  32'hFFFFFFFE, 32'h3, 32'h00000000};
        tbl[6]  = '{5'd6,  32'hFFFFFFFE, 32'h3, 32'h00000001};
        tbl[7]  = '{5'd7,  32'hFFFFFFFE, 32'h3, 32'h00000000};
        tbl[8]  = '{5'd8,  32'hFFFFFFFE, 32'h3, 32'hC0000000};
        tbl[9]  = '{5'd9,  32'h4, 32'h80000000, 32'h08000000};
        tbl[10] = '{5'd10, 32'h4, 32'h80000000, 32'hF8000000};
        tbl[11] = '{5'd11, 32'h0, 32'h1234, 32'h12340000};
        tbl[12] = '{5'd12, 32'h5, 32'h5, 32'h00000000};
        tbl[13] = '{5'd25, 32'h5, 32'h5, 32'h00000000};
        tbl[14] = '{5'd16, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE};
        tbl[15] = '{5'd17, 32'hFFFFFFFF, 32'h2, 32'h00000001};
        tbl[16] = '{5'd18, 32'd100, 32'd7, 32'd14};
        tbl[17] = '{5'd19, 32'd100, 32'd7, 32'd2};
        tbl[18] = '{5'd18, 32'd55, 32'd0, 32'hFFFFFFFF};
        tbl[19] = '{5'd19, 32'd55, 32'd0, 32'd55};

        // Reset with random inputs.
        rst = 1'b1;
        ex_a = $urandom; ex_b = $urandom; ex_d2 = $urandom; ex_td = 5'($urandom);
        ex_Aluc = 5'($urandom); ex_WREG = 1'($urandom); ex_WMEM = 1'($urandom);
        ex_LW = 1'($urandom); ex_instr = $urandom; ex_pc = $urandom;
        repeat (2) @(posedge clk);
        #1;
        check("rst instr", mem_instr, NOP);
        check("rst alu", mem_alu, 32'd0);
        check("rst d2", mem_d2, 32'd0);
        check("rst pc", mem_pc, 32'd0);
        check("rst ctrl", {26'b0, mem_td, mem_WREG, mem_WMEM, mem_LW}, 32'd0);
        check("rst busy", {31'b0, ex_busy}, 32'd0);
        ex_Aluc = 5'd0;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++)
            run_op(tbl[i].aluc, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("tbl%0d", i));

        // Reset in the middle of a multiply.
        ex_Aluc = 5'd16; ex_a = 32'd1234; ex_b = 32'd5678; ex_WREG = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        check("midop busy", {31'b0, ex_busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midop rst instr", mem_instr, NOP);
        check("midop rst wreg", {31'b0, mem_WREG}, 32'd0);
        rst = 1'b0;
        run_op(5'd0, 32'd3, 32'd4, 32'd7, "after_rst add");
        #1;
        check("after_rst idle", {31'b0, ex_busy}, 32'd0);

        // Back-to-back iterative ops: only the DONE cycle separates them.
        run_op(5'd16, 32'd6, 32'd7, 32'd42, "b2b mul");
        run_op(5'd18, 32'd42, 32'd6, 32'd7, "b2b divu");

        // Randomized ops against the reference model.
        for (int i = 0; i < 24; i++) begin
            logic [4:0]  op;
            logic [31:0] ra, rb;
            op = 5'($urandom_range(0, 31));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
            run_op(op, ra, rb, model(op, ra, rb), $sformatf("rand%0d op%0d", i, op));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
